// File: rtl/ahb_fabric_pkg.sv
// ahb_fabric_pkg: shared types, constants and decode helper
// for the parametrised AHB-Lite fabric.
package ahb_fabric_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } fabric_state_e;

    localparam int MAX_AW = 64;

    function automatic logic addr_match(
        input logic [MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0] base,
        input logic [MAX_AW-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR sequencer shared by
// unmapped accesses and watchdog timeouts.
module ahb_default_slave
    import ahb_fabric_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output fabric_state_e state,
    output logic          hready,
    output logic          hresp
);

    fabric_state_e state_q;
    fabric_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ERR2 is a ready cycle, so a new error can chain in directly.
    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        unique case (state_q)
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = start ? ST_ERR1 : ST_IDLE;
            end
            default: begin
                state_d = start ? ST_ERR1 : ST_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/ahb_lite_fabric.sv
// ahb_lite_fabric: one-master AHB-Lite interconnect with window decode,
// registered data-phase select, default slave, watchdog and error capture.
module ahb_lite_fabric
    import ahb_fabric_pkg::*;
#(
    parameter int NUM_SLAVES     = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {3{32'hFFFF_F000}},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    input  logic [2:0]                       HSIZE,
    input  logic [DATA_WIDTH-1:0]            HWDATA,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic [NUM_SLAVES-1:0]            HSEL_S,
    output logic                             HREADY_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic                             err_clear,
    output logic                             err_valid,
    output logic                             err_timeout,
    output logic [ADDR_WIDTH-1:0]            err_addr
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    htrans_e               trans;
    logic                  active;
    logic                  hit;
    logic [SW-1:0]         hit_idx;
    logic [SW-1:0]         dsel_q;
    logic [ADDR_WIDTH-1:0] daddr_q;
    logic [ADDR_WIDTH-1:0] cap_addr;
    fabric_state_e         ph_q;
    fabric_state_e         ph_d;
    fabric_state_e         ds_state;
    fabric_state_e         st;
    logic [CW-1:0]         to_cnt_q;
    logic                  sel_rdy;
    logic                  sel_resp;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  ds_ready;
    logic                  ds_resp;
    logic                  ds_start;
    logic                  timeout;
    logic                  hready_int;
    logic                  unused_ok;

    assign trans     = htrans_e'(HTRANS);
    assign active    = (trans == HTRANS_NONSEQ) ||
                       (trans == HTRANS_SEQ);
    assign unused_ok = ^{HWRITE, HSIZE, HWDATA};

    // Scan high to low so the lowest matching window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (addr_match(
                    MAX_AW'(HADDR),
                    MAX_AW'(SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
                    MAX_AW'(SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        HSEL_S = '0;
        if (active && hit) begin
            HSEL_S[hit_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_rdy  = 1'b1;
        sel_resp = HRESP_OKAY;
        sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q == SW'(i)) begin
                sel_rdy  = HREADYOUT_S[i];
                sel_resp = HRESP_S[i];
                sel_data = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign st = (ds_state != ST_IDLE) ? ds_state : ph_q;

    always_comb begin
        hready_int = 1'b1;
        HRESP      = HRESP_OKAY;
        HRDATA     = '0;
        unique case (1'b1)
            (st == ST_DATA): begin
                hready_int = sel_rdy;
                HRESP      = sel_resp;
                HRDATA     = sel_data;
            end
            (ds_state != ST_IDLE): begin
                hready_int = ds_ready;
                HRESP      = ds_resp;
            end
            default: ;
        endcase
    end

    assign HREADY   = hready_int;
    assign HREADY_S = hready_int;

    assign timeout  = (TIMEOUT_CYCLES != 0) &&
                      (st == ST_DATA) && !sel_rdy &&
                      (to_cnt_q == TO_LAST);
    assign ds_start = timeout ||
                      (hready_int && active && !hit);

    // The stalled slave is dropped on timeout; the default slave owns the bus.
    always_comb begin
        ph_d = ph_q;
        if (timeout) begin
            ph_d = ST_IDLE;
        end else if (hready_int) begin
            ph_d = (active && hit) ? ST_DATA : ST_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ph_q     <= ST_IDLE;
            dsel_q   <= '0;
            daddr_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            ph_q <= ph_d;
            if (hready_int) begin
                daddr_q  <= HADDR;
                to_cnt_q <= '0;
                if (active && hit) begin
                    dsel_q <= hit_idx;
                end
            end else if (st == ST_DATA && !sel_rdy &&
                         to_cnt_q != CNT_MAX) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    ahb_default_slave u_default (
        .clk    (HCLK),
        .rst    (HRESET),
        .start  (ds_start),
        .state  (ds_state),
        .hready (ds_ready),
        .hresp  (ds_resp)
    );

    // Unmapped errors latch the address being accepted this cycle.
    assign cap_addr = hready_int ? HADDR : daddr_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_valid   <= 1'b0;
            err_timeout <= 1'b0;
            err_addr    <= '0;
        end else if (ds_start && (!err_valid || err_clear)) begin
            err_valid   <= 1'b1;
            err_timeout <= timeout;
            err_addr    <= cap_addr;
        end else if (err_clear) begin
            err_valid   <= 1'b0;
            err_timeout <= 1'b0;
            err_addr    <= '0;
        end
    end

endmodule
